// File: rtl/com_pkg.sv
// Shared definitions for the console link: header bytes, frame length,
// frame type codes, TX/RX state encodings and the frame checksum helper.
package com_pkg;

  localparam logic [7:0] COM_HEAD0 = 8'h55;
  localparam logic [7:0] COM_HEAD1 = 8'hAA;

  localparam int         FRAME_LEN = 6;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  localparam logic [3:0] BT_CONF = 4'h1;
  localparam logic [3:0] BT_CONV = 4'h2;
  localparam logic [3:0] BT_STAT = 4'h3;
  localparam logic [3:0] BT_STOP = 4'h4;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_SEND = 2'd2,
    TX_DONE = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_H0   = 3'd0,
    RX_H1   = 3'd1,
    RX_TYPE = 3'd2,
    RX_CMDH = 3'd3,
    RX_CMDL = 3'd4,
    RX_CHK  = 3'd5
  } rx_state_e;

  // Checksum covers the type byte and both word bytes.
  function automatic logic [7:0] frame_chk(input logic [3:0] btype, input logic [15:0] word);
    return {4'h0, btype} ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/com_link_rx.sv
// RX frame parser for the console link: header sync, type check, checksum,
// drop counting (saturating err_cnt) and the optional inter-byte timeout
// enabled by defining COM_LINK_TIMEOUT_EN.
//
// state   | meaning
// RX_H0   | hunting for first header byte
// RX_H1   | expecting second header byte (repeated HEAD0 keeps us here)
// RX_TYPE | expecting type byte, upper nibble must be zero
// RX_CMDH | expecting command high byte
// RX_CMDL | expecting command low byte
// RX_CHK  | expecting checksum; accept or drop the frame
module com_link_rx
  import com_pkg::*;
#(
  parameter logic [7:0]  HEAD0   = COM_HEAD0,
  parameter logic [7:0]  HEAD1   = COM_HEAD1,
  parameter logic [15:0] TMO_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fs_read,
  output logic        frame_ok,
  output logic [3:0]  frame_btype,
  output logic [15:0] frame_cmd,
  output logic [7:0]  err_cnt
);

  rx_state_e  state, state_nxt;
  logic [3:0] type_q;
  logic [7:0] cmdh_q, cmdl_q;
  logic       err_inc;
  logic       tmo_hit;
  logic       chk_match;

`ifdef COM_LINK_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Inter-byte timer: cleared by any byte or while hunting, runs mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (rx_valid || state == RX_H0 || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = !rx_valid && (state != RX_H0) && (tmo_cnt == TMO_CYC);
`else
  logic [15:0] unused_tmo_cyc;
  assign unused_tmo_cyc = TMO_CYC;
  assign tmo_hit        = 1'b0;
`endif

  assign chk_match = (rx_data == frame_chk(type_q, {cmdh_q, cmdl_q}));

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RX_H0;
    else     state <= state_nxt;
  end

  // Next-state: advance only on rx_valid; timeout abandons a partial frame.
  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      case (state)
        RX_H0:   if (rx_data == HEAD0) state_nxt = RX_H1;
        RX_H1: begin
          if      (rx_data == HEAD1) state_nxt = RX_TYPE;
          else if (rx_data == HEAD0) state_nxt = RX_H1;
          else                       state_nxt = RX_H0;
        end
        RX_TYPE: state_nxt = (rx_data[7:4] == 4'h0) ? RX_CMDH : RX_H0;
        RX_CMDH: state_nxt = RX_CMDL;
        RX_CMDL: state_nxt = RX_CHK;
        RX_CHK:  state_nxt = RX_H0;
        default: state_nxt = RX_H0;
      endcase
    end else if (tmo_hit) begin
      state_nxt = RX_H0;
    end
  end

  // Outputs: accept strobe when checksum matches and the console is free;
  // every other terminal outcome of a started frame counts as a drop.
  always_comb begin
    frame_ok = 1'b0;
    err_inc  = tmo_hit;
    if (rx_valid) begin
      if (state == RX_TYPE && rx_data[7:4] != 4'h0) begin
        err_inc = 1'b1;
      end
      if (state == RX_CHK) begin
        if (chk_match && !fs_read) frame_ok = 1'b1;
        else                       err_inc  = 1'b1;
      end
    end
  end

  // Capture frame fields as they stream past.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q <= '0;
      cmdh_q <= '0;
      cmdl_q <= '0;
    end else if (rx_valid) begin
      if (state == RX_TYPE) type_q <= rx_data[3:0];
      if (state == RX_CMDH) cmdh_q <= rx_data;
      if (state == RX_CMDL) cmdl_q <= rx_data;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst)                             err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign frame_btype = type_q;
  assign frame_cmd   = {cmdh_q, cmdl_q};

endmodule

// File: rtl/com_link.sv
// Console link far end: TX frame serializer answering fs_send/fd_send, and
// the read-side handshake raising fs_read for each accepted RX frame.
// Optional RX inter-byte timeout: define COM_LINK_TIMEOUT_EN.
//
// state   | meaning
// TX_IDLE | waiting for fs_send
// TX_LOAD | latch type/status and checksum, reset byte index
// TX_SEND | present byte[index], advance on tx_valid & tx_ready
// TX_DONE | fd_send high until fs_send is seen low
module com_link
  import com_pkg::*;
#(
  parameter logic [7:0]  HEAD0   = COM_HEAD0,
  parameter logic [7:0]  HEAD1   = COM_HEAD1,
  parameter logic [15:0] TMO_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_send,
  output logic        fd_send,
  input  logic [3:0]  send_btype,
  input  logic [15:0] tx_stat,
  output logic        fs_read,
  input  logic        fd_read,
  output logic [3:0]  read_btype,
  output logic [15:0] com_cmd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  err_cnt
);

  tx_state_e   tx_state, tx_state_nxt;
  logic [2:0]  idx;
  logic [3:0]  btype_q;
  logic [15:0] stat_q;
  logic [7:0]  chk_q;
  logic [7:0]  cur_byte;

  logic        frame_ok;
  logic [3:0]  frame_btype;
  logic [15:0] frame_cmd;

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  // TX next-state: a frame, once loaded, always runs to completion.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (fs_send && !fd_send) tx_state_nxt = TX_LOAD;
      TX_LOAD: tx_state_nxt = TX_SEND;
      TX_SEND: if (tx_ready && idx == LAST_IDX) tx_state_nxt = TX_DONE;
      TX_DONE: if (!fs_send) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Byte selection; index only moves on an accepted byte, so data holds while stalled.
  always_comb begin
    case (idx)
      3'd0:    cur_byte = HEAD0;
      3'd1:    cur_byte = HEAD1;
      3'd2:    cur_byte = {4'h0, btype_q};
      3'd3:    cur_byte = stat_q[15:8];
      3'd4:    cur_byte = stat_q[7:0];
      default: cur_byte = chk_q;
    endcase
  end

  // TX outputs decoded from state.
  always_comb begin
    tx_valid = (tx_state == TX_SEND);
    tx_data  = (tx_state == TX_SEND) ? cur_byte : 8'h00;
    fd_send  = (tx_state == TX_DONE);
  end

  // TX datapath: latch payload on LOAD, step index per accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      btype_q <= '0;
      stat_q  <= '0;
      chk_q   <= '0;
    end else if (tx_state == TX_LOAD) begin
      idx     <= '0;
      btype_q <= send_btype;
      stat_q  <= tx_stat;
      chk_q   <= frame_chk(send_btype, tx_stat);
    end else if (tx_state == TX_SEND && tx_ready) begin
      idx     <= idx + 3'd1;
    end
  end

  com_link_rx #(
    .HEAD0   (HEAD0),
    .HEAD1   (HEAD1),
    .TMO_CYC (TMO_CYC)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fs_read     (fs_read),
    .frame_ok    (frame_ok),
    .frame_btype (frame_btype),
    .frame_cmd   (frame_cmd),
    .err_cnt     (err_cnt)
  );

  // Read handshake: publish accepted frame, hold fs_read until fd_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_read    <= 1'b0;
      read_btype <= '0;
      com_cmd    <= '0;
    end else if (frame_ok) begin
      fs_read    <= 1'b1;
      read_btype <= frame_btype;
      com_cmd    <= frame_cmd;
    end else if (fs_read && fd_read) begin
      fs_read    <= 1'b0;
    end
  end

endmodule

// File: doc/com_link.md
Name: com_link

Overview:
- Far-end partner of the console communication controller on the ETH-side fs/fd handshake.
- It is the responder for console send requests. Each `fs_send` causes one TX frame to be serialized onto a byte stream; `fd_send` is returned when the frame is done.
- It is the initiator for console read requests. Each valid RX frame is parsed, and `fs_read` is raised carrying `read_btype`/`com_cmd` until the console acknowledges.
- Sits between the console and the Ethernet byte-stream MAC wrapper.

Parameters:
- HEAD0, 8'h55, first frame header byte
- HEAD1, 8'hAA, second frame header byte
- TMO_CYC, 16'd50000, RX inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fs_send  in  1  console requests a TX frame (level)
- fd_send  out  1  TX frame complete (level)
- send_btype  in  4  frame type for TX
- tx_stat  in  16  status word placed in the TX payload
- fs_read  out  1  valid RX command available (level)
- fd_read  in  1  console has consumed the RX command
- read_btype  out  4  type of the received frame
- com_cmd  out  16  command word of the received frame
- tx_data  out  8  TX byte
- tx_valid  out  1  TX byte valid
- tx_ready  in  1  sink accepts byte when valid&ready
- rx_data  in  8  RX byte
- rx_valid  in  1  RX byte strobe; there is no backpressure
- err_cnt  out  8  saturating count of dropped RX frames

Behaviour:
- Reset: all outputs are 0. Both FSMs go to IDLE. The latched btype/stat/cmd registers are cleared. A reset mid-frame abandons the frame with no partial handshake.
- Frame format (6 bytes, both directions): HEAD0, HEAD1, {4'h0,btype}, word[15:8], word[7:0], chk. chk = XOR of bytes 2..4.
- fs/fd handshake is four-phase:
  - The requester raises fs and holds it.
  - The responder raises fd and holds it while fs=1.
  - The requester drops fs.
  - The responder drops fd on the cycle after it sees fs=0.
- TX FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: when fs_send=1 and fd_send=0, go to LOAD.
  - LOAD: one cycle. Latch send_btype/tx_stat, compute chk, set byte index=0, go to SEND.
  - SEND: tx_valid=1 with tx_data=byte[index]. The index advances on tx_valid&tx_ready. tx_data is held stable while not ready. When index 5 is accepted, go to DONE.
  - DONE: fd_send=1. When fs_send=0, go to IDLE with fd_send=0 on the next cycle.
  - Minimum latency from fs_send to fd_send with tx_ready tied 1 is 8 cycles.
  - If fs_send drops before DONE, the frame still completes. fd_send pulses for 1 cycle because fs_send is already 0.
- RX parser states: H0, H1, TYPE, CMDH, CMDL, CHK. It advances only on rx_valid.
  - H0: wait for HEAD0.
  - H1: HEAD1 advances to TYPE. HEAD0 stays in H1. Any other byte returns to H0.
  - TYPE: upper nibble must be 0, else the frame is dropped (err_cnt++, back to H0).
  - CHK: on a chk match with fs_read=0, latch read_btype/com_cmd and set fs_read=1 on the next cycle.
  - CHK mismatch: drop, err_cnt++.
  - Match while fs_read=1 (console still busy): drop, err_cnt++. Earlier outputs are not overwritten.
- Read handshake: fs_read is held until fd_read=1, then cleared on the next cycle. read_btype/com_cmd stay stable until the next accepted frame.
- err_cnt saturates at 8'hFF.
- TX and RX are fully independent. Simultaneous activity has no interaction.

Optional Feature:
- Macro: COM_LINK_TIMEOUT_EN.
- Defined:
  - A 16-bit counter resets on every rx_valid and increments while the parser is not in H0.
  - Reaching TMO_CYC returns the parser to H0 and increments err_cnt.
- Undefined: there is no counter, and the parser waits indefinitely.

Decomposition:
- Shared package com_pkg holds:
  - header constants;
  - frame length 6;
  - btype codes (BT_CONF=4'h1, BT_CONV=4'h2, BT_STAT=4'h3, BT_STOP=4'h4);
  - TX and RX state encodings.
- One natural sub-module, com_link_rx (parser, timeout, err_cnt). The TX FSM and read handshake stay in the top.

Test Plan:
- TX, tx_ready=1: fs_send=1, send_btype=4'h3, tx_stat=16'h1234 → bytes 55 AA 03 12 34 25. fd_send rises 8 cycles after fs_send. fd_send falls 1 cycle after fs_send drops.
- TX backpressure: tx_ready toggles 1/0 every cycle → same 6 bytes, no duplication, tx_data stable while stalled.
- RX good frame: bytes 55 AA 02 AB CD 64 → fs_read=1, read_btype=2, com_cmd=16'hABCD. Raising fd_read clears fs_read next cycle.
- RX errors:
  - checksum byte 00 → no fs_read, err_cnt=1;
  - TYPE byte 12 → err_cnt=2;
  - stream 55 55 AA 01 00 01 00 → accepted (repeated HEAD0 resyncs).
- RX while busy: hold fd_read=0 after frame A (cmd 0001), send frame B (cmd 0002) → com_cmd stays 0001, err_cnt increments. After ack, frame C is accepted.
- Reset mid-TX at byte 3 → tx_valid=0 and fd_send=0 next cycle. A new fs_send restarts from HEAD0. With COM_LINK_TIMEOUT_EN and TMO_CYC=16: 55 AA, then 20 idle cycles → err_cnt increments, and a following good frame is accepted.
